// File: rtl/game_sprite_control.sv
// Per-sprite motion sequencer: loads a start position on launch, steps it every
// STROBES_PER_MOVE frame strobes, and retires the sprite once it leaves the screen.
module game_sprite_control #(
  parameter int X_WIDTH          = 10,
  parameter int Y_WIDTH          = 10,
  parameter int DX_WIDTH         = 4,
  parameter int DY_WIDTH         = 4,
  parameter int START_X          = 0,
  parameter int START_Y          = 0,
  parameter int STROBES_PER_MOVE = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sprite_enable_update,
  input  logic                launch,
  input  logic [DX_WIDTH-1:0] launch_dx,
  input  logic [DY_WIDTH-1:0] launch_dy,
  input  logic                sprite_out_of_screen,
  output logic [X_WIDTH-1:0]  sprite_x,
  output logic [Y_WIDTH-1:0]  sprite_y,
  output logic                sprite_active,
  output logic                done
);

  localparam int PS_W = (STROBES_PER_MOVE > 1) ? $clog2(STROBES_PER_MOVE) : 1;
  localparam logic [X_WIDTH-1:0] START_X_V = X_WIDTH'(START_X);
  localparam logic [Y_WIDTH-1:0] START_Y_V = Y_WIDTH'(START_Y);
  localparam logic [PS_W-1:0]    PS_LAST   = PS_W'(STROBES_PER_MOVE - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    RETIRE = 2'd2
  } state_t;

  state_t                r_state;
  logic [X_WIDTH-1:0]    r_x;
  logic [Y_WIDTH-1:0]    r_y;
  logic [DX_WIDTH-1:0]   r_dx;
  logic [DY_WIDTH-1:0]   r_dy;
  logic [PS_W-1:0]       r_prescaler;
  logic                  r_moved;
  logic                  r_active;
  logic                  r_done;

  logic                  w_ps_last;
  logic [X_WIDTH-1:0]    w_next_x;
  logic [Y_WIDTH-1:0]    w_next_y;

  function automatic logic [X_WIDTH-1:0] sext_x(input logic [DX_WIDTH-1:0] d);
    return {{(X_WIDTH-DX_WIDTH){d[DX_WIDTH-1]}}, d};
  endfunction

  function automatic logic [Y_WIDTH-1:0] sext_y(input logic [DY_WIDTH-1:0] d);
    return {{(Y_WIDTH-DY_WIDTH){d[DY_WIDTH-1]}}, d};
  endfunction

  // Position arithmetic wraps modulo the coordinate width by construction.
  assign w_ps_last = (r_prescaler == PS_LAST);
  assign w_next_x  = r_x + sext_x(r_dx);
  assign w_next_y  = r_y + sext_y(r_dy);

  // Sequencer state, position and handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_x         <= START_X_V;
      r_y         <= START_Y_V;
      r_dx        <= '0;
      r_dy        <= '0;
      r_prescaler <= '0;
      r_moved     <= 1'b0;
      r_active    <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (launch) begin
        r_state     <= ACTIVE;
        r_x         <= START_X_V;
        r_y         <= START_Y_V;
        r_dx        <= launch_dx;
        r_dy        <= launch_dy;
        r_prescaler <= '0;
        r_moved     <= 1'b0;
        r_active    <= 1'b1;
      end else begin
        case (r_state)
          IDLE: begin
            r_state <= IDLE;
          end
          ACTIVE: begin
            // Off-screen is only trusted after the first step, so a lagging or
            // off-screen start position cannot retire the sprite immediately.
            if (sprite_enable_update) begin
              if (r_moved && sprite_out_of_screen) begin
                r_state  <= RETIRE;
                r_active <= 1'b0;
                r_done   <= 1'b1;
              end else if (w_ps_last) begin
                r_x         <= w_next_x;
                r_y         <= w_next_y;
                r_prescaler <= '0;
                r_moved     <= 1'b1;
              end else begin
                r_prescaler <= r_prescaler + PS_W'(1);
              end
            end else begin
              r_state <= ACTIVE;
            end
          end
          RETIRE: begin
            r_state <= IDLE;
          end
          default: begin
            r_state  <= IDLE;
            r_active <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sprite_x      = r_x;
  assign sprite_y      = r_y;
  assign sprite_active = r_active;
  assign done          = r_done;

endmodule

// File: tb/tb_game_sprite_control.sv
// Directed bench for game_sprite_control: a vector table for the single-step
// instance plus hand sequences for reset, restart and the 3-strobe prescaler.
module tb_game_sprite_control;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       strobe = 1'b0;
  logic       launch = 1'b0;
  logic [3:0] ldx = 4'd0;
  logic [3:0] ldy = 4'd0;
  logic       oos = 1'b0;

  logic [9:0] xa, ya, xb, yb;
  logic       aa, da, ab, db;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  game_sprite_control #(.STROBES_PER_MOVE(1)) u_a (
    .clk(clk), .reset(reset), .sprite_enable_update(strobe), .launch(launch),
    .launch_dx(ldx), .launch_dy(ldy), .sprite_out_of_screen(oos),
    .sprite_x(xa), .sprite_y(ya), .sprite_active(aa), .done(da)
  );

  game_sprite_control #(.STROBES_PER_MOVE(3)) u_b (
    .clk(clk), .reset(reset), .sprite_enable_update(strobe), .launch(launch),
    .launch_dx(ldx), .launch_dy(ldy), .sprite_out_of_screen(oos),
    .sprite_x(xb), .sprite_y(yb), .sprite_active(ab), .done(db)
  );

  typedef struct {
    logic       l;
    logic [3:0] dx;
    logic [3:0] dy;
    logic       s;
    logic       o;
    logic [9:0] ex;
    logic [9:0] ey;
    logic       ea;
    logic       ed;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] actual=%0d expected=%0d", nm, idx, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic cyc(input logic l, input logic [3:0] dx, input logic [3:0] dy,
                     input logic s, input logic o);
    launch = l; ldx = dx; ldy = dy; strobe = s; oos = o;
    @(posedge clk);
    #1;
    launch = 1'b0; strobe = 1'b0;
  endtask

  task automatic chk_a(input string nm, input int idx, input logic [9:0] ex,
                       input logic [9:0] ey, input logic ea, input logic ed);
    chk({nm, "_x"}, idx, 16'(xa), 16'(ex));
    chk({nm, "_y"}, idx, 16'(ya), 16'(ey));
    chk({nm, "_active"}, idx, 16'(aa), 16'(ea));
    chk({nm, "_done"}, idx, 16'(da), 16'(ed));
  endtask

  initial begin
    logic [9:0] exp_b[7];

    //        l     dx     dy     s     o     x        y        act   done
    vecs[0]  = '{1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 10'd0,    10'd0,    1'b0, 1'b0};
    vecs[1]  = '{1'b1, 4'd2, 4'hF, 1'b0, 1'b0, 10'd0,    10'd0,    1'b1, 1'b0};
    vecs[2]  = '{1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 10'd2,    10'd1023, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 10'd4,    10'd1022, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 10'd6,    10'd1021, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 10'd6,    10'd1021, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 4'd1, 4'd0, 1'b1, 1'b0, 10'd0,    10'd0,    1'b1, 1'b0};
    vecs[7]  = '{1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 10'd1,    10'd0,    1'b1, 1'b0};
    vecs[8]  = '{1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 10'd1,    10'd0,    1'b0, 1'b1};
    vecs[9]  = '{1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 10'd1,    10'd0,    1'b0, 1'b0};
    vecs[10] = '{1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 10'd1,    10'd0,    1'b0, 1'b0};
    vecs[11] = '{1'b1, 4'hF, 4'd1, 1'b0, 1'b0, 10'd0,    10'd0,    1'b1, 1'b0};
    vecs[12] = '{1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 10'd1023, 10'd1,    1'b1, 1'b0};
    vecs[13] = '{1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 10'd1022, 10'd2,    1'b1, 1'b0};
    vecs[14] = '{1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 10'd1022, 10'd2,    1'b0, 1'b1};
    vecs[15] = '{1'b1, 4'd1, 4'd0, 1'b0, 1'b0, 10'd0,    10'd0,    1'b1, 1'b0};
    vecs[16] = '{1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 10'd1,    10'd0,    1'b1, 1'b0};

    exp_b = '{10'd0, 10'd0, 10'd1, 10'd1, 10'd1, 10'd2, 10'd2};

    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_a("reset", 0, 10'd0, 10'd0, 1'b0, 1'b0);

    for (int i = 0; i < 17; i++) begin
      cyc(vecs[i].l, vecs[i].dx, vecs[i].dy, vecs[i].s, vecs[i].o);
      chk_a("vec", i, vecs[i].ex, vecs[i].ey, vecs[i].ea, vecs[i].ed);
    end
    oos = 1'b0;

    // Reset while in flight at x=50.
    cyc(1'b1, 4'd5, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
    chk_a("pre_reset", 0, 10'd50, 10'd0, 1'b1, 1'b0);
    reset = 1'b1;
    cyc(1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
    reset = 1'b0;
    chk_a("mid_reset", 0, 10'd0, 10'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
    chk_a("post_reset", 0, 10'd0, 10'd0, 1'b0, 1'b0);

    // Launch and strobe together at x=100: restart wins, no step applied.
    cyc(1'b1, 4'd5, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
    chk_a("at100", 0, 10'd100, 10'd0, 1'b1, 1'b0);
    cyc(1'b1, 4'd1, 4'd0, 1'b1, 1'b0);
    chk_a("relaunch", 0, 10'd0, 10'd0, 1'b1, 1'b0);
    cyc(1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
    chk_a("relaunch_step", 0, 10'd1, 10'd0, 1'b1, 1'b0);

    // Prescaled instance: step only every third strobe.
    reset = 1'b1;
    cyc(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    reset = 1'b0;
    chk("b_reset_active", 0, 16'(ab), 16'd0);
    cyc(1'b1, 4'd1, 4'd0, 1'b0, 1'b0);
    chk("b_launch_active", 0, 16'(ab), 16'd1);
    for (int i = 0; i < 7; i++) begin
      cyc(1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
      chk("b_step_x", i + 1, 16'(xb), 16'(exp_b[i]));
    end
    // Relaunch mid-count must clear the prescaler.
    cyc(1'b1, 4'd1, 4'd0, 1'b0, 1'b0);
    cyc(1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
    cyc(1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
    cyc(1'b1, 4'd1, 4'd0, 1'b1, 1'b0);
    chk("b_relaunch_x", 0, 16'(xb), 16'd0);
    cyc(1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
    cyc(1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
    chk("b_ps_hold_x", 0, 16'(xb), 16'd0);
    cyc(1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
    chk("b_ps_step_x", 0, 16'(xb), 16'd1);
    chk("b_done", 0, 16'(db), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
